// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer for the MIPS-subset CPU: FETCH/DECODE/EXEC/MEM/WB
// with a req/ready handshake on the shared instruction/data memory port.
module multicycle_ctrl (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic [5:0] Function_opcode,
  input  logic       Zero,
  input  logic       Mem_ready,
  output logic       Mem_req,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic [1:0] PCSrc,
  output logic       RegWrite,
  output logic       RegDST,
  output logic       MemtoReg,
  output logic       Jal,
  output logic [1:0] ALUOp,
  output logic       ALUSrc,
  output logic       I_format,
  output logic       Sftmd,
  output logic       Jr,
  output logic       Illegal,
  output logic [2:0] State
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    C_NONE = 4'd0,
    C_R    = 4'd1,
    C_I    = 4'd2,
    C_LW   = 4'd3,
    C_SW   = 4'd4,
    C_BEQ  = 4'd5,
    C_BNE  = 4'd6,
    C_J    = 4'd7,
    C_JAL  = 4'd8,
    C_ILL  = 4'd9
  } cls_t;

  state_t     r_state, w_next;
  cls_t       r_cls, w_cls;
  logic [1:0] r_aluop;
  logic       r_alusrc, r_ifmt, r_sftmd, r_jr, r_regdst, r_memtoreg, r_jal;

  logic w_rfmt, w_ifmt, w_lw, w_sw, w_beq, w_bne, w_j, w_jal;

  assign w_rfmt = (Opcode == 6'b000000);
  assign w_ifmt = (Opcode[5:3] == 3'b001);
  assign w_lw   = (Opcode == 6'b100011);
  assign w_sw   = (Opcode == 6'b101011);
  assign w_beq  = (Opcode == 6'b000100);
  assign w_bne  = (Opcode == 6'b000101);
  assign w_j    = (Opcode == 6'b000010);
  assign w_jal  = (Opcode == 6'b000011);

  always_comb begin
    w_cls = C_ILL;
    if      (w_rfmt) w_cls = C_R;
    else if (w_ifmt) w_cls = C_I;
    else if (w_lw)   w_cls = C_LW;
    else if (w_sw)   w_cls = C_SW;
    else if (w_beq)  w_cls = C_BEQ;
    else if (w_bne)  w_cls = C_BNE;
    else if (w_j)    w_cls = C_J;
    else if (w_jal)  w_cls = C_JAL;
  end

  // Fields are captured only while leaving DECODE so the ALU sees stable
  // controls from EXEC through WB even though IR/Opcode may move on.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_FETCH;
      r_cls      <= C_NONE;
      r_aluop    <= 2'b00;
      r_alusrc   <= 1'b0;
      r_ifmt     <= 1'b0;
      r_sftmd    <= 1'b0;
      r_jr       <= 1'b0;
      r_regdst   <= 1'b0;
      r_memtoreg <= 1'b0;
      r_jal      <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_cls      <= w_cls;
        r_aluop    <= {w_rfmt | w_ifmt, w_beq | w_bne};
        r_alusrc   <= w_ifmt | w_lw | w_sw;
        r_ifmt     <= w_ifmt;
        r_sftmd    <= w_rfmt && (Function_opcode[5:3] == 3'b000);
        r_jr       <= w_rfmt && (Function_opcode == 6'b001000);
        r_regdst   <= w_rfmt;
        r_memtoreg <= w_lw;
        r_jal      <= w_jal;
      end
    end
  end

  always_comb begin
    w_next   = r_state;
    Mem_req  = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    PCSrc    = 2'b00;
    RegWrite = 1'b0;
    Illegal  = 1'b0;
    case (r_state)
      S_FETCH: begin
        Mem_req = 1'b1;
        MemRead = 1'b1;
        if (Mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          w_next  = S_DECODE;
        end
      end
      S_DECODE: w_next = S_EXEC;
      S_EXEC: begin
        w_next = S_FETCH;
        case (r_cls)
          C_BEQ: if (Zero)  begin PCWrite = 1'b1; PCSrc = 2'b01; end
          C_BNE: if (!Zero) begin PCWrite = 1'b1; PCSrc = 2'b01; end
          C_J:   begin PCWrite = 1'b1; PCSrc = 2'b10; end
          C_JAL: begin PCWrite = 1'b1; PCSrc = 2'b10; w_next = S_WB; end
          C_R: begin
            if (r_jr) begin
              PCWrite = 1'b1;
              PCSrc   = 2'b11;
            end else begin
              w_next = S_WB;
            end
          end
          C_I:         w_next  = S_WB;
          C_LW, C_SW:  w_next  = S_MEM;
          C_ILL:       Illegal = 1'b1;
          default:     w_next  = S_FETCH;
        endcase
      end
      S_MEM: begin
        Mem_req  = 1'b1;
        MemRead  = (r_cls == C_LW);
        MemWrite = (r_cls == C_SW);
        if (Mem_ready) w_next = (r_cls == C_LW) ? S_WB : S_FETCH;
      end
      S_WB: begin
        RegWrite = 1'b1;
        w_next   = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
    if (reset) begin
      Mem_req  = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      PCSrc    = 2'b00;
      RegWrite = 1'b0;
      Illegal  = 1'b0;
    end
  end

  assign State    = r_state;
  assign ALUOp    = r_aluop;
  assign ALUSrc   = r_alusrc;
  assign I_format = r_ifmt;
  assign Sftmd    = r_sftmd;
  assign Jr       = r_jr;
  assign RegDST   = r_regdst;
  assign MemtoReg = r_memtoreg;
  assign Jal      = r_jal;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expected records are queued by
// an instruction-level reference model and compared by an independent monitor.
module tb_multicycle_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] Opcode = 6'd0;
  logic [5:0] Function_opcode = 6'd0;
  logic       Zero = 1'b0;
  logic       Mem_ready = 1'b1;
  logic       Mem_req, MemRead, MemWrite, IRWrite, PCWrite;
  logic [1:0] PCSrc;
  logic       RegWrite, RegDST, MemtoReg, Jal;
  logic [1:0] ALUOp;
  logic       ALUSrc, I_format, Sftmd, Jr, Illegal;
  logic [2:0] State;

  multicycle_ctrl dut (
    .clock(clock), .reset(reset), .Opcode(Opcode), .Function_opcode(Function_opcode),
    .Zero(Zero), .Mem_ready(Mem_ready), .Mem_req(Mem_req), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc),
    .RegWrite(RegWrite), .RegDST(RegDST), .MemtoReg(MemtoReg), .Jal(Jal),
    .ALUOp(ALUOp), .ALUSrc(ALUSrc), .I_format(I_format), .Sftmd(Sftmd), .Jr(Jr),
    .Illegal(Illegal), .State(State)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [2:0] st;
    logic       req, rd, wr, irw, pcw;
    logic [1:0] pcsrc;
    logic       rw, ill;
    logic [1:0] aluop;
    logic       alusrc, ifmt, sftmd, jr, regdst, m2r, jal;
  } rec_t;

  rec_t expq[$];
  rec_t cur_f = '0;
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  // Monitor: one record per cycle, sampled at the falling edge.
  always @(negedge clock) begin
    rec_t e, a;
    cyc++;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      a.st = State;  a.req = Mem_req; a.rd = MemRead; a.wr = MemWrite;
      a.irw = IRWrite; a.pcw = PCWrite; a.pcsrc = PCSrc; a.rw = RegWrite;
      a.ill = Illegal; a.aluop = ALUOp; a.alusrc = ALUSrc; a.ifmt = I_format;
      a.sftmd = Sftmd; a.jr = Jr; a.regdst = RegDST; a.m2r = MemtoReg; a.jal = Jal;
      n_vec++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL cycle%0d ctrl_record got=%h exp=%h (st %0d/%0d)", cyc, a, e, a.st, e.st);
      end
    end
  end

  function automatic rec_t fields(input logic [5:0] op, input logic [5:0] fn);
    rec_t f = '0;
    logic r, i, lw, sw, bq, bn;
    r  = (op == 6'd0);
    i  = (op[5:3] == 3'b001);
    lw = (op == 6'b100011);
    sw = (op == 6'b101011);
    bq = (op == 6'b000100);
    bn = (op == 6'b000101);
    f.aluop  = {r | i, bq | bn};
    f.alusrc = i | lw | sw;
    f.ifmt   = i;
    f.sftmd  = r && (fn[5:3] == 3'b000);
    f.jr     = r && (fn == 6'b001000);
    f.regdst = r;
    f.m2r    = lw;
    f.jal    = (op == 6'b000011);
    return f;
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return (op == 6'd0) || (op[5:3] == 3'b001) || (op == 6'b100011) || (op == 6'b101011) ||
           (op == 6'b000100) || (op == 6'b000101) || (op == 6'b000010) || (op == 6'b000011);
  endfunction

  function automatic rec_t mk(input logic [2:0] st, input logic req, rd, wr, irw, pcw,
                              input logic [1:0] pcsrc, input logic rw, ill);
    rec_t e = cur_f;
    e.st = st; e.req = req; e.rd = rd; e.wr = wr; e.irw = irw; e.pcw = pcw;
    e.pcsrc = pcsrc; e.rw = rw; e.ill = ill;
    return e;
  endfunction

  task automatic step(input logic rst, input logic rdy, input logic [5:0] op,
                      input logic [5:0] fn, input logic z, input rec_t e);
    @(posedge clock);
    #1;
    reset = rst; Mem_ready = rdy; Opcode = op; Function_opcode = fn; Zero = z;
    expq.push_back(e);
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected cycle trace of one instruction, built from the sequencing rules.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int fw, input int mw);
    logic r, i, lw, sw, bq, bn, j, jl, jr, ill, taken, pcw, to_wb;
    logic [1:0] src;
    r  = (op == 6'd0);  i = (op[5:3] == 3'b001);
    lw = (op == 6'b100011); sw = (op == 6'b101011);
    bq = (op == 6'b000100); bn = (op == 6'b000101);
    j  = (op == 6'b000010); jl = (op == 6'b000011);
    jr = r && (fn == 6'b001000);
    ill   = !is_legal(op);
    taken = (bq && z) || (bn && !z);
    pcw   = taken || j || jl || jr;
    src   = taken ? 2'b01 : (j || jl) ? 2'b10 : jr ? 2'b11 : 2'b00;
    to_wb = (r && !jr) || i || jl || lw;
    for (int k = 0; k < fw; k++)
      step(1'b0, 1'b0, 6'($urandom), 6'($urandom), rb(), mk(3'd0, 1, 1, 0, 0, 0, 2'b00, 0, 0));
    step(1'b0, 1'b1, 6'($urandom), 6'($urandom), rb(), mk(3'd0, 1, 1, 0, 1, 1, 2'b00, 0, 0));
    step(1'b0, rb(), op, fn, rb(), mk(3'd1, 0, 0, 0, 0, 0, 2'b00, 0, 0));
    cur_f = fields(op, fn);
    step(1'b0, rb(), 6'($urandom), 6'($urandom), z, mk(3'd2, 0, 0, 0, 0, pcw, src, 0, ill));
    if (lw || sw) begin
      for (int k = 0; k < mw; k++)
        step(1'b0, 1'b0, 6'($urandom), 6'($urandom), rb(), mk(3'd3, 1, lw, sw, 0, 0, 2'b00, 0, 0));
      step(1'b0, 1'b1, 6'($urandom), 6'($urandom), rb(), mk(3'd3, 1, lw, sw, 0, 0, 2'b00, 0, 0));
    end
    if (to_wb)
      step(1'b0, rb(), 6'($urandom), 6'($urandom), rb(), mk(3'd4, 0, 0, 0, 0, 0, 2'b00, 1, 0));
  endtask

  logic [5:0] rop, rfn;
  int kind;

  initial begin
    // Two reset cycles with memory ready: nothing may be requested.
    cur_f = '0;
    step(1'b1, 1'b1, 6'd0, 6'd0, 1'b0, mk(3'd0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
    step(1'b1, 1'b1, 6'd0, 6'd0, 1'b0, mk(3'd0, 0, 0, 0, 0, 0, 2'b00, 0, 0));

    run_instr(6'b000000, 6'b100000, 1'b0, 0, 0);  // add
    run_instr(6'b100011, 6'b000000, 1'b0, 1, 2);  // lw, 2 MEM waits
    run_instr(6'b000100, 6'b000000, 1'b1, 0, 0);  // beq taken
    run_instr(6'b000101, 6'b000000, 1'b1, 0, 0);  // bne not taken
    run_instr(6'b000000, 6'b000000, 1'b0, 0, 0);  // sll
    run_instr(6'b000000, 6'b001000, 1'b0, 0, 0);  // jr
    run_instr(6'b111111, 6'b000000, 1'b0, 0, 0);  // illegal
    run_instr(6'b101011, 6'b000000, 1'b0, 0, 1);  // sw
    run_instr(6'b000011, 6'b000000, 1'b0, 0, 0);  // jal
    run_instr(6'b000010, 6'b000000, 1'b0, 0, 0);  // j
    run_instr(6'b001000, 6'b000000, 1'b0, 2, 0);  // addi

    // sw interrupted by reset during a MEM wait: no write strobe, back to FETCH.
    step(1'b0, 1'b1, 6'd0, 6'd0, 1'b0, mk(3'd0, 1, 1, 0, 1, 1, 2'b00, 0, 0));
    step(1'b0, 1'b0, 6'b101011, 6'd0, 1'b0, mk(3'd1, 0, 0, 0, 0, 0, 2'b00, 0, 0));
    cur_f = fields(6'b101011, 6'd0);
    step(1'b0, 1'b0, 6'd0, 6'd0, 1'b0, mk(3'd2, 0, 0, 0, 0, 0, 2'b00, 0, 0));
    step(1'b0, 1'b0, 6'd0, 6'd0, 1'b0, mk(3'd3, 1, 0, 1, 0, 0, 2'b00, 0, 0));
    step(1'b1, 1'b1, 6'd0, 6'd0, 1'b0, mk(3'd3, 0, 0, 0, 0, 0, 2'b00, 0, 0));
    cur_f = '0;
    step(1'b0, 1'b0, 6'd0, 6'd0, 1'b0, mk(3'd0, 1, 1, 0, 0, 0, 2'b00, 0, 0));

    for (int n = 0; n < 120; n++) begin
      kind = $urandom_range(0, 11);
      rfn  = 6'($urandom);
      case (kind)
        0:  begin rop = 6'd0; rfn = 6'b001000; end
        1:  begin rop = 6'd0; rfn = {3'b000, 3'($urandom)}; end
        2:  rop = 6'd0;
        3:  rop = {3'b001, 3'($urandom)};
        4:  rop = 6'b100011;
        5:  rop = 6'b101011;
        6:  rop = 6'b000100;
        7:  rop = 6'b000101;
        8:  rop = 6'b000010;
        9:  rop = 6'b000011;
        default: begin
          rop = 6'($urandom);
          while (is_legal(rop)) rop = 6'($urandom);
        end
      endcase
      run_instr(rop, rfn, rb(), $urandom_range(0, 2), $urandom_range(0, 2));
    end

    repeat (3) @(posedge clock);
    if (expq.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain left=%0d required=0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control sequencer for the MIPS-subset CPU. Steps each instruction through fetch, decode, execute, memory and write-back states. Drives the ALU control inputs (ALUOp, ALUSrc, I_format, Sftmd, Jr) and the PC, IR, register-file and memory enables. Handles a req/ready handshake with the shared instruction/data memory port, so that port can insert wait states.

## Interface
- No parameters; state encoding is fixed: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
- clock  in  1  sole clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- Opcode  in  6  instruction[31:26], valid from IR while in DECODE
- Function_opcode  in  6  instruction[5:0], valid from IR while in DECODE
- Zero  in  1  ALU zero flag, sampled in EXEC
- Mem_ready  in  1  memory completes the access in the cycle it is high
- Mem_req  out  1  memory access request
- MemRead  out  1  read qualifier for Mem_req
- MemWrite  out  1  write qualifier for Mem_req
- IRWrite  out  1  load IR
- PCWrite  out  1  load PC
- PCSrc  out  2  PC source: 00 PC+4, 01 Addr_Result, 10 jump target, 11 Read_data_1
- RegWrite  out  1  register-file write enable
- RegDST  out  1  write register is rd (1) or rt (0)
- MemtoReg  out  1  write-back data from memory
- Jal  out  1  write-back targets $31 with PC+4
- ALUOp  out  2  {R_format|I_format, beq|bne}
- ALUSrc  out  1  second ALU operand is the immediate
- I_format  out  1  Opcode[5:3]==3'b001
- Sftmd  out  1  R_format && Function_opcode[5:3]==3'b000
- Jr  out  1  R_format && Function_opcode==6'b001000
- Illegal  out  1  one-cycle pulse on an unsupported opcode
- State  out  3  current state, for debug

## Operation
- Decode fields are registered on the DECODE->EXEC edge and held until the next DECODE->EXEC edge. They are ALUOp, ALUSrc, I_format, Sftmd, Jr, RegDST, MemtoReg, Jal and the latched opcode class.
- R_format: Opcode==0. lw=100011, sw=101011, beq=000100, bne=000101, j=000010, jal=000011.
- ALUSrc = I_format|lw|sw.
- Strobes are combinational from state, registered fields and inputs. All strobes are 0 outside the states listed below.
- FETCH: Mem_req=1, MemRead=1. When Mem_ready=1: IRWrite=1, PCWrite=1, PCSrc=00, go to DECODE. Otherwise stay in FETCH.
- DECODE: no strobes; go to EXEC.
- EXEC:
  - beq with Zero=1, or bne with Zero=0: PCWrite=1, PCSrc=01.
  - j: PCWrite=1, PCSrc=10. jal: PCWrite=1, PCSrc=10.
  - jr: PCWrite=1, PCSrc=11.
- EXEC next state:
  - lw/sw: go to MEM.
  - R-type other than jr, I_format, and jal: go to WB.
  - All other cases: go to FETCH.
- MEM: Mem_req=1. MemRead=1 for lw, MemWrite=1 for sw. When Mem_ready=1, go to WB for lw or FETCH for sw.
- WB: RegWrite=1 for one cycle; go to FETCH.
- Unsupported opcode (none of R-type, I_format, lw, sw, beq, bne, j, jal): Illegal=1 in EXEC, treated as NOP, go to FETCH.

## Timing
- Reset: State=FETCH and all registered fields 0 after the first edge with reset=1.
  - While reset=1, every strobe is forced to 0, including Mem_req.
  - Reset mid-access abandons the access; there is no completion pulse.
- Zero-wait memory (Mem_ready already high) gives these cycle counts:
  - beq/bne/j/jr: 3
  - R-type/I_format/sw/jal: 4
  - lw: 5
- Each memory wait cycle adds 1 cycle.
- Mem_req stays high from state entry until the cycle Mem_ready=1, inclusive. Mem_ready is ignored outside FETCH/MEM.
- MemRead and MemWrite are never high together. PCWrite is never high for more than one cycle per state visit.
- IRWrite and PCWrite fire in the same cycle, the ready cycle of FETCH. PC and IR update on the following edge.
- Zero is sampled combinationally in the single EXEC cycle. ALU inputs are stable there because the fields are registered.
- ALU control fields stay constant through MEM and WB, so ALU_Result holds for the address and write-back.

## Test plan
- Reset: reset=1 for 2 cycles with Mem_ready=1 -> State=0 and Mem_req=0 during reset. Mem_req=1 in the first cycle after release.
- R-type add (Opcode=0, Function=100000), Mem_ready=1 -> State sequence 0,1,2,4,0. ALUOp=10, ALUSrc=0, RegDST=1. RegWrite=1 only in cycle 4.
- lw with 2 wait cycles in MEM -> State sequence 0,1,2,3,3,3,4,0. Mem_req=1 and MemRead=1 for all three MEM cycles. MemtoReg=1, ALUSrc=1, ALUOp=00.
- beq with Zero=1, then bne with Zero=1:
  - beq: PCWrite=1, PCSrc=01 in EXEC.
  - bne: PCWrite=0.
  - Both: ALUOp=01, return to FETCH after 3 cycles.
- sll (Function=000000) -> Sftmd=1. jr (Function=001000) -> Jr=1, PCSrc=11, 3 cycles, RegWrite never 1.
- Opcode=111111 -> Illegal=1 for 1 cycle in EXEC, then FETCH. Separately, reset asserted during a MEM wait -> next State=0, no MemWrite pulse.
